serpario_ctrl: RTL and testbench

//   Frame sequencer for the board's serial<->parallel I/O expander chain (SER_OUT/SH_CLK/STORE/OUT_EN to the

---
 rtl/serpario_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_serpario_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serpario_ctrl.sv
// Frame sequencer for the serial<->parallel I/O expander chain.
// Shifts a snapshotted output word out MSB-first while sampling the input chain,
// strobes STORE to latch/load, and optionally refreshes frames automatically.
module serpario_ctrl #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned REFRESH_CYCLES = 1000
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] in_data,
    output logic             in_valid,
    output logic             busy,
    output logic             SER_OUT,
    input  logic             SER_IN,
    output logic             SH_CLK,
    output logic             STORE,
    output logic             OUT_EN
);

    localparam int unsigned DIV_W        = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W        = $clog2(WIDTH);
    localparam int unsigned REF_W        = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned REF_LAST_INT = (REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1;
    localparam bit          REF_EN       = (REFRESH_CYCLES != 0);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(WIDTH - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_LAST_INT);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StShiftLo = 2'd1;
    localparam logic [1:0] StShiftHi = 2'd2;
    localparam logic [1:0] StLatch   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] shift_out_q, shift_out_d;
    logic [WIDTH-1:0] shift_in_q, shift_in_d;
    logic [WIDTH-1:0] in_data_q, in_data_d;
    logic [REF_W-1:0] refresh_q, refresh_d;
    logic             pending_q, pending_d;
    logic             in_valid_q, in_valid_d;
    logic             out_en_q, out_en_d;
    logic             busy_q, busy_d;
    logic             sh_clk_q, sh_clk_d;
    logic             store_q, store_d;
    logic             ser_out_q, ser_out_d;

    logic div_last;
    logic refresh_hit;
    logic frame_go;

    assign div_last    = (div_q == DIV_LAST);
    assign refresh_hit = REF_EN && (refresh_q == REF_LAST);

    // Next-state logic: frame sequencing, start/pending arbitration, refresh counting
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_out_d = shift_out_q;
        shift_in_d  = shift_in_q;
        in_data_d   = in_data_q;
        refresh_d   = refresh_q;
        pending_d   = pending_q;
        in_valid_d  = 1'b0;
        out_en_d    = out_en_q;
        frame_go    = 1'b0;

        case (state_q)
            StIdle: begin
                frame_go = enable && (start || pending_q || refresh_hit);
                if (frame_go) begin
                    // start and a pending/refresh request in the same cycle merge into one frame
                    state_d     = StShiftLo;
                    shift_out_d = out_data;
                    shift_in_d  = '0;
                    bit_d       = BIT_TOP;
                    div_d       = '0;
                    pending_d   = 1'b0;
                    refresh_d   = '0;
                end else begin
                    if (start) begin
                        pending_d = 1'b1;
                    end
                    if (enable && REF_EN && !refresh_hit) begin
                        refresh_d = refresh_q + 1'b1;
                    end
                end
            end
            StShiftLo: begin
                if (div_last) begin
                    div_d      = '0;
                    shift_in_d = {shift_in_q[WIDTH-2:0], SER_IN};
                    state_d    = StShiftHi;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShiftHi: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == '0) begin
                        state_d = StLatch;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        state_d = StShiftLo;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StLatch: begin
                if (div_last) begin
                    div_d      = '0;
                    state_d    = StIdle;
                    in_data_d  = shift_in_q;
                    in_valid_d = 1'b1;
                    // outputs stay enabled once the first frame has been latched
                    out_en_d   = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Requests arriving mid-frame are remembered; refresh counter rests at 0 while busy
        if (state_q != StIdle) begin
            refresh_d = '0;
            if (start) begin
                pending_d = 1'b1;
            end
        end
    end

    // Pin outputs are derived from the next state so they are registered and glitch-free
    always_comb begin
        busy_d    = (state_d != StIdle);
        sh_clk_d  = (state_d == StShiftHi);
        store_d   = (state_d == StLatch);
        ser_out_d = 1'b0;
        if (state_d == StShiftLo || state_d == StShiftHi) begin
            ser_out_d = shift_out_d[bit_d];
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bit_q       <= '0;
            shift_out_q <= '0;
            shift_in_q  <= '0;
            in_data_q   <= '0;
            refresh_q   <= '0;
            pending_q   <= 1'b0;
            in_valid_q  <= 1'b0;
            out_en_q    <= 1'b1;
            busy_q      <= 1'b0;
            sh_clk_q    <= 1'b0;
            store_q     <= 1'b0;
            ser_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_out_q <= shift_out_d;
            shift_in_q  <= shift_in_d;
            in_data_q   <= in_data_d;
            refresh_q   <= refresh_d;
            pending_q   <= pending_d;
            in_valid_q  <= in_valid_d;
            out_en_q    <= out_en_d;
            busy_q      <= busy_d;
            sh_clk_q    <= sh_clk_d;
            store_q     <= store_d;
            ser_out_q   <= ser_out_d;
        end
    end

    assign in_data  = in_data_q;
    assign in_valid = in_valid_q;
    assign busy     = busy_q;
    assign SER_OUT  = ser_out_q;
    assign SH_CLK   = sh_clk_q;
    assign STORE    = store_q;
    assign OUT_EN   = out_en_q;

endmodule

// File: tb/tb_serpario_ctrl.sv
// Bench for serpario_ctrl: two instances (refresh off / refresh every 20 cycles)
// share the same stimulus; each is compared every cycle with a frame-timeline model.
module tb_serpario_ctrl;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int T  = 2 * D * W;  // cycles spent shifting bits
    localparam int FL = T + D + 1;  // start cycle to in_valid cycle

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         start;
    logic [W-1:0] out_data;
    logic         ser_in [2];

    logic [W-1:0] in_data0, in_data1;
    logic         in_valid0, in_valid1, busy0, busy1;
    logic         ser_out0, ser_out1, sh_clk0, sh_clk1;
    logic         store0, store1, out_en0, out_en1;

    always #5 clk = ~clk;

    serpario_ctrl #(.WIDTH(W), .CLK_DIV(D), .REFRESH_CYCLES(0)) u_dut0 (
        .clk_i(clk), .reset_n(reset_n), .enable(enable), .start(start),
        .out_data(out_data), .in_data(in_data0), .in_valid(in_valid0), .busy(busy0),
        .SER_OUT(ser_out0), .SER_IN(ser_in[0]), .SH_CLK(sh_clk0), .STORE(store0),
        .OUT_EN(out_en0)
    );

    serpario_ctrl #(.WIDTH(W), .CLK_DIV(D), .REFRESH_CYCLES(20)) u_dut1 (
        .clk_i(clk), .reset_n(reset_n), .enable(enable), .start(start),
        .out_data(out_data), .in_data(in_data1), .in_valid(in_valid1), .busy(busy1),
        .SER_OUT(ser_out1), .SER_IN(ser_in[1]), .SH_CLK(sh_clk1), .STORE(store1),
        .OUT_EN(out_en1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit model_on = 1'b0;

    // Model state per instance
    bit           m_act  [2];
    int           m_start[2];
    logic [W-1:0] m_word [2];
    logic [W-1:0] m_inw  [2];
    logic [W-1:0] m_data [2];
    logic [W-1:0] next_in[2];
    bit           m_pend [2];
    bit           m_oe   [2];
    int           m_ref  [2];
    int           refc   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_act[d]  = 1'b0;
        m_pend[d] = 1'b0;
        m_ref[d]  = 0;
        m_data[d] = '0;
        m_oe[d]   = 1'b1;
    endtask

    // Expected pins for this cycle from position within the frame, then apply this cycle's inputs
    task automatic model_step(input int d, input logic [5:0] obs, input logic [W-1:0] obs_data);
        logic [5:0] exp;
        logic       sh;
        bit         busy_now;
        bit         hit;
        int         t;
        int         k;
        exp      = {5'b00000, m_oe[d]};
        busy_now = 1'b0;
        if (m_act[d]) begin
            t = cyc - m_start[d];
            if (t <= T) begin
                k        = (t - 1) / (2 * D);
                sh       = (((t - 1) / D) % 2) == 1;
                exp      = {1'b1, sh, 1'b0, m_word[d][W-1-k], 1'b0, m_oe[d]};
                busy_now = 1'b1;
            end else if (t <= T + D) begin
                exp      = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_oe[d]};
                busy_now = 1'b1;
            end else begin
                m_data[d] = m_inw[d];
                m_oe[d]   = 1'b0;
                m_act[d]  = 1'b0;
                exp       = 6'b000010;
            end
        end
        if (model_on) begin
            check($sformatf("d%0d_pins@%0d", d, cyc), 32'(obs), 32'(exp));
            check($sformatf("d%0d_in_data@%0d", d, cyc), 32'(obs_data), 32'(m_data[d]));
        end
        if (!reset_n) begin
            model_reset(d);
        end else if (busy_now) begin
            if (start) m_pend[d] = 1'b1;
        end else begin
            hit = (refc[d] != 0) && (m_ref[d] == refc[d] - 1);
            if (enable && (start || m_pend[d] || hit)) begin
                m_act[d]   = 1'b1;
                m_start[d] = cyc;
                m_word[d]  = out_data;
                m_inw[d]   = next_in[d];
                next_in[d] = W'($urandom);
                m_pend[d]  = 1'b0;
                m_ref[d]   = 0;
            end else begin
                if (start) m_pend[d] = 1'b1;
                if (enable && refc[d] != 0 && !hit) m_ref[d]++;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        model_step(0, {busy0, sh_clk0, store0, ser_out0, in_valid0, out_en0}, in_data0);
        model_step(1, {busy1, sh_clk1, store1, ser_out1, in_valid1, out_en1}, in_data1);
    end

    // Input shift register model: present the next input bit MSB-first during each low phase
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (m_act[d] && (cyc - m_start[d]) >= 1 && (cyc - m_start[d]) <= T) begin
                ser_in[d] = m_inw[d][W-1-((cyc - m_start[d] - 1) / (2 * D))];
            end else begin
                ser_in[d] = 1'($urandom);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [W-1:0] word);
        out_data = word;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        refc[0] = 0;
        refc[1] = 20;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            next_in[d] = W'($urandom);
        end
        ser_in[0] = 1'b0;
        ser_in[1] = 1'b0;
        reset_n  = 1'b0;
        enable   = 1'b0;
        start    = 1'b0;
        out_data = '0;
        wait_n(2);
        model_on = 1'b1;
        wait_n(2);
        reset_n = 1'b1;
        wait_n(2);

        // Basic frame, input capture, mid-frame out_data change
        enable = 1'b1;
        next_in[0] = 8'h3C;
        pulse(8'hA5);
        wait_n(4);
        out_data = 8'hFF;
        wait_n(35);
        next_in[0] = 8'hC3;
        pulse(8'hFF);
        wait_n(40);

        // Starts at N, N+10, N+12: one pending frame only
        pulse(8'h5A);
        wait_n(9);
        pulse(8'h0F);
        wait_n(1);
        pulse(8'h81);
        wait_n(80);

        // Reset mid-frame, then a fresh full frame
        pulse(8'h96);
        wait_n(14);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_n(3);
        enable = 1'b1;
        pulse(8'h69);
        wait_n(40);

        // Refresh running, enable drop, start while disabled
        wait_n(150);
        enable = 1'b0;
        wait_n(60);
        pulse(8'h77);
        wait_n(10);
        enable = 1'b1;
        wait_n(50);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            out_data = W'($urandom);
            start    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            reset_n  = ($urandom_range(0, 1499) != 0);
            tick();
        end
        start   = 1'b0;
        reset_n = 1'b1;
        wait_n(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
